decode_stage: RTL and testbench



---
 rtl/decode_stage.sv | 127 ++++++++++++
 tb/tb_decode_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Dual-slot RISC-V field decoder between fetch and rename; both slots decode
// independently into one registered bundle with 1-cycle latency and no stall.
module decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  PC1_di,
  input  logic [6:0]  PC2_di,
  input  logic [31:0] c_di,
  input  logic        en_flag_di,
  input  logic [31:0] instr_1,
  input  logic [31:0] instr_2,
  output logic [6:0]  opcode_do_1,
  output logic [6:0]  opcode_do_2,
  output logic [2:0]  func3_do_1,
  output logic [2:0]  func3_do_2,
  output logic [6:0]  func7_do_1,
  output logic [6:0]  func7_do_2,
  output logic [4:0]  rs1_do_1,
  output logic [4:0]  rs1_do_2,
  output logic [4:0]  rs2_do_1,
  output logic [4:0]  rs2_do_2,
  output logic [4:0]  rd_do_1,
  output logic [4:0]  rd_do_2,
  output logic [31:0] instr_do_1,
  output logic [31:0] instr_do_2,
  output logic        en_flag_do,
  output logic [31:0] c_do,
  output logic [6:0]  PC1_do,
  output logic [6:0]  PC2_do
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] instr;
  } slot_t;

  // Unsupported opcodes and disabled bundles collapse to an all-zero bubble.
  function automatic slot_t decode(input logic [31:0] w, input logic en);
    slot_t d;
    d = '0;
    if (en) begin
      case (w[6:0])
        OP_R: begin
          d.rd = w[11:7]; d.func3 = w[14:12]; d.rs1 = w[19:15];
          d.rs2 = w[24:20]; d.func7 = w[31:25];
        end
        OP_I: begin
          d.rd = w[11:7]; d.func3 = w[14:12]; d.rs1 = w[19:15];
          if (w[14:12] == 3'b001 || w[14:12] == 3'b101) d.func7 = w[31:25];
        end
        OP_LOAD: begin
          d.rd = w[11:7]; d.func3 = w[14:12]; d.rs1 = w[19:15];
        end
        OP_STORE: begin
          d.func3 = w[14:12]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
        end
        OP_LUI: d.rd = w[11:7];
        default: d = '0;
      endcase
      if (w[6:0] inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_LUI}) begin
        d.opcode = w[6:0];
        d.instr  = w;
      end
    end
    return d;
  endfunction

  slot_t slot1_c, slot2_c;
  slot_t slot1_q, slot2_q;
  logic        en_q;
  logic [31:0] c_q;
  logic [6:0]  pc1_q, pc2_q;

  always_comb begin
    slot1_c = decode(instr_1, en_flag_di);
    slot2_c = decode(instr_2, en_flag_di);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot1_q <= '0;
      slot2_q <= '0;
      en_q    <= 1'b0;
      c_q     <= '0;
      pc1_q   <= '0;
      pc2_q   <= '0;
    end else begin
      slot1_q <= slot1_c;
      slot2_q <= slot2_c;
      en_q    <= en_flag_di;
      c_q     <= c_di;
      pc1_q   <= PC1_di;
      pc2_q   <= PC2_di;
    end
  end

  assign opcode_do_1 = slot1_q.opcode;
  assign func3_do_1  = slot1_q.func3;
  assign func7_do_1  = slot1_q.func7;
  assign rs1_do_1    = slot1_q.rs1;
  assign rs2_do_1    = slot1_q.rs2;
  assign rd_do_1     = slot1_q.rd;
  assign instr_do_1  = slot1_q.instr;
  assign opcode_do_2 = slot2_q.opcode;
  assign func3_do_2  = slot2_q.func3;
  assign func7_do_2  = slot2_q.func7;
  assign rs1_do_2    = slot2_q.rs1;
  assign rs2_do_2    = slot2_q.rs2;
  assign rd_do_2     = slot2_q.rd;
  assign instr_do_2  = slot2_q.instr;
  assign en_flag_do  = en_q;
  assign c_do        = c_q;
  assign PC1_do      = pc1_q;
  assign PC2_do      = pc2_q;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized and directed bench for decode_stage against a field-presence table model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  PC1_di, PC2_di;
  logic [31:0] c_di;
  logic        en_flag_di;
  logic [31:0] instr_1, instr_2;
  logic [6:0]  opcode_do_1, opcode_do_2;
  logic [2:0]  func3_do_1, func3_do_2;
  logic [6:0]  func7_do_1, func7_do_2;
  logic [4:0]  rs1_do_1, rs1_do_2, rs2_do_1, rs2_do_2, rd_do_1, rd_do_2;
  logic [31:0] instr_do_1, instr_do_2;
  logic        en_flag_do;
  logic [31:0] c_do;
  logic [6:0]  PC1_do, PC2_do;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .PC1_di(PC1_di), .PC2_di(PC2_di), .c_di(c_di), .en_flag_di(en_flag_di),
    .instr_1(instr_1), .instr_2(instr_2),
    .opcode_do_1(opcode_do_1), .opcode_do_2(opcode_do_2),
    .func3_do_1(func3_do_1), .func3_do_2(func3_do_2),
    .func7_do_1(func7_do_1), .func7_do_2(func7_do_2),
    .rs1_do_1(rs1_do_1), .rs1_do_2(rs1_do_2),
    .rs2_do_1(rs2_do_1), .rs2_do_2(rs2_do_2),
    .rd_do_1(rd_do_1), .rd_do_2(rd_do_2),
    .instr_do_1(instr_do_1), .instr_do_2(instr_do_2),
    .en_flag_do(en_flag_do), .c_do(c_do), .PC1_do(PC1_do), .PC2_do(PC2_do)
  );

  typedef struct packed {
    logic [31:0] opcode, func3, func7, rs1, rs2, rd, instr;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: each format is a row of which fields exist in the word.
  function automatic exp_t model(input logic [31:0] w, input logic en);
    exp_t e;
    int op;
    bit known, has_rd, has_rs1, has_rs2, has_f3, has_f7;
    e  = '0;
    op = int'(w[6:0]);
    known = en && (op == 'h33 || op == 'h13 || op == 'h03 || op == 'h23 || op == 'h37);
    if (!known) return e;
    has_rd  = (op != 'h23);
    has_rs1 = (op != 'h37);
    has_f3  = (op != 'h37);
    has_rs2 = (op == 'h33) || (op == 'h23);
    has_f7  = (op == 'h33) || (op == 'h13 && (((w >> 12) & 7) == 1 || ((w >> 12) & 7) == 5));
    e.opcode = w & 32'h7f;
    e.instr  = w;
    if (has_rd)  e.rd    = (w >> 7)  & 32'h1f;
    if (has_f3)  e.func3 = (w >> 12) & 32'h7;
    if (has_rs1) e.rs1   = (w >> 15) & 32'h1f;
    if (has_rs2) e.rs2   = (w >> 20) & 32'h1f;
    if (has_f7)  e.func7 = w >> 25;
    return e;
  endfunction

  task automatic check_all(input string tag, input exp_t e1, input exp_t e2,
                           input logic en, input logic [31:0] c,
                           input logic [6:0] pc1, input logic [6:0] pc2);
    check({tag, ".op1"},  32'(opcode_do_1), e1.opcode);
    check({tag, ".f31"},  32'(func3_do_1),  e1.func3);
    check({tag, ".f71"},  32'(func7_do_1),  e1.func7);
    check({tag, ".rs11"}, 32'(rs1_do_1),    e1.rs1);
    check({tag, ".rs21"}, 32'(rs2_do_1),    e1.rs2);
    check({tag, ".rd1"},  32'(rd_do_1),     e1.rd);
    check({tag, ".ins1"}, instr_do_1,       e1.instr);
    check({tag, ".op2"},  32'(opcode_do_2), e2.opcode);
    check({tag, ".f32"},  32'(func3_do_2),  e2.func3);
    check({tag, ".f72"},  32'(func7_do_2),  e2.func7);
    check({tag, ".rs12"}, 32'(rs1_do_2),    e2.rs1);
    check({tag, ".rs22"}, 32'(rs2_do_2),    e2.rs2);
    check({tag, ".rd2"},  32'(rd_do_2),     e2.rd);
    check({tag, ".ins2"}, instr_do_2,       e2.instr);
    check({tag, ".en"},   32'(en_flag_do),  32'(en));
    check({tag, ".c"},    c_do,             c);
    check({tag, ".pc1"},  32'(PC1_do),      32'(pc1));
    check({tag, ".pc2"},  32'(PC2_do),      32'(pc2));
  endtask

  task automatic check_zero(input string tag);
    check_all(tag, '0, '0, 1'b0, 32'd0, 7'd0, 7'd0);
  endtask

  task automatic set_in(input logic [31:0] i1, input logic [31:0] i2,
                        input logic [6:0] p1, input logic [6:0] p2,
                        input logic [31:0] c, input logic en);
    instr_1 = i1; instr_2 = i2; PC1_di = p1; PC2_di = p2; c_di = c; en_flag_di = en;
  endtask

  // Apply a bundle at the falling edge and check it just after the next rising edge.
  task automatic run(input string tag, input logic [31:0] i1, input logic [31:0] i2,
                     input logic [6:0] p1, input logic [6:0] p2,
                     input logic [31:0] c, input logic en);
    @(negedge clk);
    set_in(i1, i2, p1, p2, c, en);
    @(posedge clk);
    #1;
    check_all(tag, model(i1, en), model(i2, en), en, c, p1, p2);
  endtask

  // Hand-derived expectations for the named instructions.
  task automatic check_directed();
    check("add.op",  32'(opcode_do_1), 32'h33);
    check("add.rd",  32'(rd_do_1), 32'd3);
    check("add.rs1", 32'(rs1_do_1), 32'd1);
    check("add.rs2", 32'(rs2_do_1), 32'd2);
    check("sub.rd",  32'(rd_do_2), 32'd5);
    check("sub.rs1", 32'(rs1_do_2), 32'd6);
    check("sub.rs2", 32'(rs2_do_2), 32'd7);
    check("sub.f7",  32'(func7_do_2), 32'h20);
  endtask

  initial begin
    logic [6:0] ops [6];
    logic [31:0] w1, w2;
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03;
    ops[3] = 7'h23; ops[4] = 7'h37; ops[5] = 7'h00;

    rst_n = 1'b0;
    set_in(32'h002081B3, 32'h407302B3, 7'd1, 7'd2, 32'd3, 1'b1);
    #1;
    check_zero("reset");
    @(posedge clk);
    #1;
    check_zero("reset_edge");
    @(negedge clk);
    rst_n = 1'b1;

    run("add_sub", 32'h002081B3, 32'h407302B3, 7'd0, 7'd4, 32'd1, 1'b1);
    check_directed();
    run("addi_srai", 32'h00500093, 32'h4032D293, 7'd8, 7'd12, 32'd2, 1'b1);
    check("srai.f3", 32'(func3_do_2), 32'd5);
    check("srai.f7", 32'(func7_do_2), 32'h20);
    check("addi.f7", 32'(func7_do_1), 32'd0);
    run("lw_sw", 32'h0000A203, 32'h0020A423, 7'd16, 7'd20, 32'd3, 1'b1);
    check("lw.f3", 32'(func3_do_1), 32'd2);
    check("sw.rd", 32'(rd_do_2), 32'd0);
    run("lui_bub", 32'h12345337, 32'h00000000, 7'd24, 7'd28, 32'd4, 1'b1);
    check("lui.ins", instr_do_1, 32'h12345337);
    check("bub.ins", instr_do_2, 32'd0);
    run("en_off", 32'h002081B3, 32'h00500093, 7'd8, 7'd12, 32'd5, 1'b0);
    check("en_off.rd1", 32'(rd_do_1), 32'd0);
    run("pc_wrap", 32'h002081B3, 32'hFFFFFFFF, 7'd127, 7'd0, 32'hDEADBEEF, 1'b1);

    for (int k = 0; k < 300; k++) begin
      w1 = $urandom;
      w2 = $urandom;
      if ($urandom_range(0, 5) != 0) w1[6:0] = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 5) != 0) w2[6:0] = ops[$urandom_range(0, 5)];
      run("rand", w1, w2, 7'($urandom), 7'($urandom), $urandom,
          1'($urandom_range(0, 4) != 0));
    end

    // Reset dropped between edges while a new bundle waits at the inputs.
    run("pre_rst", 32'h002081B3, 32'h407302B3, 7'd40, 7'd44, 32'd9, 1'b1);
    @(negedge clk);
    set_in(32'h00500093, 32'h12345337, 7'd48, 7'd52, 32'd10, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_async");
    @(posedge clk);
    #1;
    check_zero("rst_hold1");
    @(posedge clk);
    #1;
    check_zero("rst_hold2");
    @(negedge clk);
    rst_n = 1'b1;
    set_in(32'h0000A203, 32'h0020A423, 7'd60, 7'd64, 32'd11, 1'b1);
    #1;
    check_zero("rst_release");
    @(posedge clk);
    #1;
    check_all("post_rst", model(32'h0000A203, 1'b1), model(32'h0020A423, 1'b1),
              1'b1, 32'd11, 7'd60, 7'd64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
